// File: rtl/ex_div.sv
// ex_div: multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} one quotient bit per cycle and stalls the pipeline while busy.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVZERO,
        S_ON,
        S_END
    } state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_negQ;
    logic               r_negR;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quotNext;
    logic [WIDTH-1:0]   w_qFinal;
    logic [WIDTH-1:0]   w_rFinal;
    logic               w_lastIter;

    // Signed operands are reduced to magnitudes; 0x80000000 maps cleanly onto unsigned 2^31.
    assign w_neg1 = signed_div_i & opdata1_i[WIDTH-1];
    assign w_neg2 = signed_div_i & opdata2_i[WIDTH-1];
    assign w_abs1 = w_neg1 ? -opdata1_i : opdata1_i;
    assign w_abs2 = w_neg2 ? -opdata2_i : opdata2_i;

    // Partial remainder stays below the divisor, so the top bit of the
    // (WIDTH+1)-bit difference is an exact borrow flag.
    assign w_shifted  = {r_rem, r_quot[WIDTH-1]};
    assign w_diff     = w_shifted - {1'b0, r_divisor};
    assign w_borrow   = w_diff[WIDTH];
    assign w_remNext  = w_borrow ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quotNext = {r_quot[WIDTH-2:0], ~w_borrow};
    assign w_qFinal   = r_negQ ? -w_quotNext : w_quotNext;
    assign w_rFinal   = r_negR ? -w_remNext : w_remNext;
    assign w_lastIter = (r_count == LAST_ITER);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (div_start_i) begin
                    w_nextState = (opdata2_i == '0) ? S_DIVZERO : S_ON;
                end
            end
            S_DIVZERO: w_nextState = S_END;
            S_ON: begin
                if (w_lastIter) begin
                    w_nextState = S_END;
                end
            end
            S_END: begin
                if (!div_start_i) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
        if (annul_i) begin
            w_nextState = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count   <= '0;
            r_quot    <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else if (annul_i) begin
            r_count  <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                    if (div_start_i) begin
                        r_quot    <= w_abs1;
                        r_divisor <= w_abs2;
                        r_rem     <= '0;
                        r_negQ    <= w_neg1 ^ w_neg2;
                        r_negR    <= w_neg1;
                        r_count   <= '0;
                    end
                end
                S_DIVZERO: begin
                    r_result <= '0;
                    r_ready  <= 1'b1;
                end
                S_ON: begin
                    r_rem  <= w_remNext;
                    r_quot <= w_quotNext;
                    if (w_lastIter) begin
                        r_count  <= '0;
                        r_result <= {w_rFinal, w_qFinal};
                        r_ready  <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                S_END: begin
                    if (!div_start_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_result <= '0;
                    r_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o   = r_result;
    assign ready_o    = r_ready;
    assign stallreq_o = div_start_i & ~r_ready;

endmodule
